// File: rtl/fifo_read_packer.sv
// Drain stage for sync_fifo: pops WIDTH-bit words and packs PACK of them into one
// wide valid/ready beat; a flush emits whatever has been collected so far.
module fifo_read_packer #(
  parameter int WIDTH = 4,
  parameter int PACK  = 4,
  parameter int CNT_W = $clog2(PACK + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    empty_i,
  input  logic [WIDTH-1:0]        rdata_i,
  input  logic                    fifo_err_i,
  output logic                    rd_en_o,
  input  logic                    flush_i,
  output logic [WIDTH*PACK-1:0]   out_data_o,
  output logic [CNT_W-1:0]        out_cnt_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    err_o
);

  // Handshake: a beat transfers on a rising edge where out_valid_o && out_ready_i;
  // once raised, out_valid_o and the payload hold until that transfer happens.

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            issued_q, issued_d;
  logic [CNT_W-1:0]            recv_q, recv_d;
  logic                        rd_pend_q, rd_pend_d;
  logic                        flush_q, flush_d;
  logic                        err_q, err_d;
  logic [PACK-1:0][WIDTH-1:0]  lanes_q, lanes_d;
  logic                        rd_en;

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    recv_d    = recv_q;
    rd_pend_d = 1'b0;
    flush_d   = flush_q;
    lanes_d   = lanes_q;
    rd_en     = 1'b0;

    case (state_q)
      ST_FILL: begin
        // Gated by rst_ni so the pop request drops the instant reset asserts.
        rd_en     = rst_ni && !empty_i && (issued_q < CNT_W'(PACK)) && !flush_q;
        rd_pend_d = rd_en;
        if (rd_en) begin
          issued_d = issued_q + CNT_W'(1);
        end
        if (rd_pend_q) begin
          for (int i = 0; i < PACK; i++) begin
            if (recv_q == CNT_W'(i)) begin
              lanes_d[i] = rdata_i;
            end
          end
          recv_d = recv_q + CNT_W'(1);
        end
        if (flush_i && ((issued_q != '0) || rd_en)) begin
          flush_d = 1'b1;
        end
        // Close the word once every issued pop has landed and it is full or flushed.
        if (!rd_pend_d && (recv_d == issued_d) && (issued_d != '0) &&
            ((issued_d == CNT_W'(PACK)) || flush_d)) begin
          state_d = ST_HOLD;
          flush_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (out_ready_i) begin
          state_d  = ST_FILL;
          issued_d = '0;
          recv_d   = '0;
          flush_d  = 1'b0;
          lanes_d  = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase

    err_d = err_q | (fifo_err_i & rd_pend_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_FILL;
      issued_q  <= '0;
      recv_q    <= '0;
      rd_pend_q <= 1'b0;
      flush_q   <= 1'b0;
      err_q     <= 1'b0;
      lanes_q   <= '0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      recv_q    <= recv_d;
      rd_pend_q <= rd_pend_d;
      flush_q   <= flush_d;
      err_q     <= err_d;
      lanes_q   <= lanes_d;
    end
  end

  assign rd_en_o     = rd_en;
  assign out_valid_o = (state_q == ST_HOLD);
  assign out_cnt_o   = (state_q == ST_HOLD) ? recv_q : '0;
  assign out_data_o  = (state_q == ST_HOLD) ? lanes_q : '0;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer: a small queue-based FIFO feeds it and a
// monitor compares each accepted beat against hand-computed expectations.
module tb_fifo_read_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        empty_i = 1'b1;
  logic [3:0]  rdata_i = '0;
  logic        fifo_err_i;
  logic        rd_en_o;
  logic        flush_i;
  logic [15:0] out_data_o;
  logic [2:0]  out_cnt_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        err_o;

  fifo_read_packer #(.WIDTH(4), .PACK(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .empty_i     (empty_i),
    .rdata_i     (rdata_i),
    .fifo_err_i  (fifo_err_i),
    .rd_en_o     (rd_en_o),
    .flush_i     (flush_i),
    .out_data_o  (out_data_o),
    .out_cnt_o   (out_cnt_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .err_o       (err_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: registered read data and registered empty flag
  logic [3:0] fifo_q[$];
  logic [3:0] push_q[$];

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      fifo_q.delete();
      empty_i <= 1'b1;
      rdata_i <= '0;
    end else begin
      if (rd_en_o && fifo_q.size() > 0) rdata_i <= fifo_q.pop_front();
      while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
      empty_i <= (fifo_q.size() == 0);
    end
  end

  task automatic push(input logic [3:0] w);
    push_q.push_back(w);
  endtask

  // scoreboard: {cnt[2:0], data[15:0]}
  logic [18:0] exp_q[$];
  int pops = 0;
  int beats = 0;
  int cyc = 0;
  int last_cyc = 0;
  bit have_last = 0;
  bit chk_period = 0;

  always begin
    logic [18:0] e;
    @(negedge clk_i);
    #4;
    cyc++;
    if (!chk_period) have_last = 0;
    if (!rst_ni) begin
      pops = 0;
    end else begin
      if (rd_en_o) pops++;
      if (out_valid_o && out_ready_i) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", {16'h0, out_data_o}, {16'h0, e[15:0]});
          check("beat_cnt", {29'h0, out_cnt_o}, {29'h0, e[18:16]});
          check("pops_per_beat", pops, {29'h0, e[18:16]});
        end
        pops = 0;
        if (chk_period && have_last) check("beat_period", cyc - last_cyc, 6);
        last_cyc = cyc;
        have_last = chk_period;
      end
    end
  end

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk_i);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  initial begin
    int n;
    int b0;
    rst_ni      = 1'b0;
    fifo_err_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_rd_en", rd_en_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_cnt", out_cnt_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_err", err_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // T1: one full word
    exp_q.push_back({3'd4, 16'h4321});
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    wait_drain(40);

    // T2: backpressure in HOLD
    out_ready_i = 1'b0;
    push(4'h5); push(4'h6); push(4'h7); push(4'h8);
    n = 0;
    while (!out_valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    push(4'hA); push(4'hB);
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      check("hold_rd_en", rd_en_o, 0);
      check("hold_valid", out_valid_o, 1);
      check("hold_data", out_data_o, 16'h8765);
      check("hold_cnt", out_cnt_o, 4);
      check("hold_fifo_cnt", fifo_q.size(), 2);
      @(negedge clk_i);
    end
    exp_q.push_back({3'd4, 16'h8765});
    out_ready_i = 1'b1;
    wait_drain(10);

    // T3: flush a partial word, then flush with nothing issued
    repeat (6) @(negedge clk_i);
    exp_q.push_back({3'd2, 16'h00BA});
    pulse_flush();
    wait_drain(20);
    b0 = beats;
    pulse_flush();
    repeat (10) @(negedge clk_i);
    check("empty_flush_beats", beats - b0, 0);
    check("empty_flush_valid", out_valid_o, 0);

    // T4: stream of 16 words
    chk_period = 1;
    exp_q.push_back({3'd4, 16'h3210});
    exp_q.push_back({3'd4, 16'h7654});
    exp_q.push_back({3'd4, 16'hBA98});
    exp_q.push_back({3'd4, 16'hFEDC});
    for (int i = 0; i < 16; i++) push(4'(i));
    wait_drain(120);
    chk_period = 0;
    check("stream_err", err_o, 0);

    // T5: reset mid-word
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    n = 0;
    while (pops < 3 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    rst_ni = 1'b0;
    #1;
    check("mid_rst_rd_en", rd_en_o, 0);
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_cnt", out_cnt_o, 0);
    check("mid_rst_data", out_data_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    exp_q.push_back({3'd4, 16'hFEDC});
    push(4'hC); push(4'hD); push(4'hE); push(4'hF);
    wait_drain(40);

    // T6: FIFO error while a read is pending
    exp_q.push_back({3'd2, 16'h0021});
    push(4'h1); push(4'h2);
    n = 0;
    while (!rd_en_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    fifo_err_i = 1'b1;
    @(negedge clk_i);
    fifo_err_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("err_set", err_o, 1);
      @(negedge clk_i);
    end
    pulse_flush();
    wait_drain(20);
    check("err_sticky", err_o, 1);
    rst_ni = 1'b0;
    #1;
    check("err_cleared", err_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
